// File: rtl/axi_slave_decerr_pkg.sv
// ---------------------------------------------------------------------------
// axi_slave_decerr_pkg
//   Shared AXI constants for the default (decode-error) slave:
//   - RESP encodings (OKAY / EXOKAY / SLVERR / DECERR)
//   - channel field widths (ID / ADDR / DATA / STRB / LEN)
//   - state encodings for the write and read FSMs
// ---------------------------------------------------------------------------
package axi_slave_decerr_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int LEN_W  = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi_slave_decerr_sat_counter.sv
// ---------------------------------------------------------------------------
// axi_slave_decerr_sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk  - clock
//     clr  - synchronous clear (highest priority)
//     inc  - add one this cycle unless already saturated
//     cnt  - current count
// ---------------------------------------------------------------------------
module axi_slave_decerr_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/axi_slave_decerr.sv
// ---------------------------------------------------------------------------
// axi_slave_decerr
//   Default AXI4 slave for unmapped addresses. Every write and read is
//   completed with RESP=DECERR so a master never hangs on a missing slave.
//
//   Handshake rule (all five channels): a transfer happens on the rising
//   clk edge where both VALID and READY are 1. A VALID, once raised by
//   this block, holds together with its payload until that edge.
//
//   Ports:
//     clk, rst                 - clock, synchronous active-high reset
//     SLAVE_CLK, SLAVE_RSTN    - clock / active-low reset passed downstream
//     SLAVE_WR_ADDR_*          - write address channel (AW)
//     SLAVE_WR_DATA_*          - write data channel (W), data is discarded
//     SLAVE_WR_BACK_*          - write response channel (B)
//     SLAVE_RD_ADDR_*          - read address channel (AR)
//     SLAVE_RD_* (data side)   - read data channel (R)
//     WR_ERR_CNT, RD_ERR_CNT   - saturating counts of completed B / R bursts
//     ERR_ADDR                 - address of the last accepted transaction
//     DBG_WR_STATE/RD_STATE    - current write / read FSM state
// ---------------------------------------------------------------------------
module axi_slave_decerr
    import axi_slave_decerr_pkg::*;
#(
    parameter logic [DATA_W-1:0] DATA_PATTERN = 32'hDEAD_BEEF,
    parameter int                CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 SLAVE_CLK,
    output logic                 SLAVE_RSTN,
    // write address
    input  logic [ID_W-1:0]      SLAVE_WR_ADDR_ID,
    input  logic [ADDR_W-1:0]    SLAVE_WR_ADDR,
    input  logic [LEN_W-1:0]     SLAVE_WR_ADDR_LEN,
    input  logic [1:0]           SLAVE_WR_ADDR_BURST,
    input  logic                 SLAVE_WR_ADDR_VALID,
    output logic                 SLAVE_WR_ADDR_READY,
    // write data
    input  logic [DATA_W-1:0]    SLAVE_WR_DATA,
    input  logic [STRB_W-1:0]    SLAVE_WR_STRB,
    input  logic                 SLAVE_WR_DATA_LAST,
    input  logic                 SLAVE_WR_DATA_VALID,
    output logic                 SLAVE_WR_DATA_READY,
    // write response
    output logic [ID_W-1:0]      SLAVE_WR_BACK_ID,
    output logic [1:0]           SLAVE_WR_BACK_RESP,
    output logic                 SLAVE_WR_BACK_VALID,
    input  logic                 SLAVE_WR_BACK_READY,
    // read address
    input  logic [ID_W-1:0]      SLAVE_RD_ADDR_ID,
    input  logic [ADDR_W-1:0]    SLAVE_RD_ADDR,
    input  logic [LEN_W-1:0]     SLAVE_RD_ADDR_LEN,
    input  logic [1:0]           SLAVE_RD_ADDR_BURST,
    input  logic                 SLAVE_RD_ADDR_VALID,
    output logic                 SLAVE_RD_ADDR_READY,
    // read data
    output logic [ID_W-1:0]      SLAVE_RD_BACK_ID,
    output logic [DATA_W-1:0]    SLAVE_RD_DATA,
    output logic [1:0]           SLAVE_RD_DATA_RESP,
    output logic                 SLAVE_RD_DATA_LAST,
    output logic                 SLAVE_RD_DATA_VALID,
    input  logic                 SLAVE_RD_DATA_READY,
    // debug
    output logic [CNT_WIDTH-1:0] WR_ERR_CNT,
    output logic [CNT_WIDTH-1:0] RD_ERR_CNT,
    output logic [ADDR_W-1:0]    ERR_ADDR,
    output logic [1:0]           DBG_WR_STATE,
    output logic                 DBG_RD_STATE
);

    // Payload fields that a decode-error slave has no use for.
    logic unused_inputs;
    assign unused_inputs = ^{SLAVE_WR_ADDR_LEN, SLAVE_WR_ADDR_BURST,
                             SLAVE_WR_DATA, SLAVE_WR_STRB, SLAVE_RD_ADDR_BURST};

    assign SLAVE_CLK  = clk;
    assign SLAVE_RSTN = ~rst;

    // -----------------------------------------------------------------------
    // Write FSM
    // -----------------------------------------------------------------------
    w_state_t        w_state, w_next;
    logic            aw_ready, wd_ready, b_valid;
    logic [ID_W-1:0] b_id;
    logic [1:0]      b_resp;
    logic            aw_ready_d, wd_ready_d, b_valid_d;
    logic [1:0]      b_resp_d;
    logic            aw_hs, w_hs, b_hs, wr_inc;

    assign aw_hs = SLAVE_WR_ADDR_VALID && aw_ready;
    assign w_hs  = SLAVE_WR_DATA_VALID && wd_ready;
    assign b_hs  = b_valid && SLAVE_WR_BACK_READY;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        wr_inc = 1'b0;
        case (w_state)
            W_IDLE: if (aw_hs) w_next = W_DATA;
            W_DATA: if (w_hs && SLAVE_WR_DATA_LAST) w_next = W_RESP;
            W_RESP: begin
                if (b_hs) begin
                    w_next = W_IDLE;
                    wr_inc = 1'b1;
                end
            end
            default: w_next = W_IDLE;
        endcase

        // Outputs are registered from the next state, so each channel
        // reacts exactly one cycle after the handshake that moved the FSM.
        aw_ready_d = (w_next == W_IDLE);
        wd_ready_d = (w_next == W_DATA);
        b_valid_d  = (w_next == W_RESP);
        b_resp_d   = (w_next == W_RESP) ? RESP_DECERR : RESP_OKAY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_ready <= 1'b0;
            wd_ready <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
            b_id     <= '0;
        end else begin
            aw_ready <= aw_ready_d;
            wd_ready <= wd_ready_d;
            b_valid  <= b_valid_d;
            b_resp   <= b_resp_d;
            if (aw_hs) b_id <= SLAVE_WR_ADDR_ID;
        end
    end

    assign SLAVE_WR_ADDR_READY = aw_ready;
    assign SLAVE_WR_DATA_READY = wd_ready;
    assign SLAVE_WR_BACK_VALID = b_valid;
    assign SLAVE_WR_BACK_ID    = b_id;
    assign SLAVE_WR_BACK_RESP  = b_resp;
    assign DBG_WR_STATE        = w_state;

    // -----------------------------------------------------------------------
    // Read FSM
    // -----------------------------------------------------------------------
    r_state_t          r_state, r_next;
    logic [LEN_W-1:0]  r_cnt, r_cnt_d;
    logic              ar_ready, rd_valid, rd_last;
    logic [ID_W-1:0]   rd_id;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        rd_resp;
    logic              ar_ready_d, rd_valid_d, rd_last_d;
    logic [DATA_W-1:0] rd_data_d;
    logic [1:0]        rd_resp_d;
    logic              ar_hs, r_hs, rd_inc;

    assign ar_hs = SLAVE_RD_ADDR_VALID && ar_ready;
    assign r_hs  = rd_valid && SLAVE_RD_DATA_READY;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next  = r_state;
        r_cnt_d = r_cnt;
        rd_inc  = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_next  = R_DATA;
                    r_cnt_d = SLAVE_RD_ADDR_LEN;
                end
            end
            R_DATA: begin
                // r_cnt counts remaining beats after the current one; it
                // is only decremented while non-zero, so it cannot wrap.
                if (r_hs) begin
                    if (r_cnt != '0) begin
                        r_cnt_d = r_cnt - LEN_W'(1);
                    end else begin
                        r_next = R_IDLE;
                        rd_inc = 1'b1;
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase

        ar_ready_d = (r_next == R_IDLE);
        rd_valid_d = (r_next == R_DATA);
        rd_last_d  = rd_valid_d && (r_cnt_d == '0);
        rd_data_d  = rd_valid_d ? DATA_PATTERN : '0;
        rd_resp_d  = rd_valid_d ? RESP_DECERR : RESP_OKAY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            ar_ready <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
            rd_resp  <= RESP_OKAY;
            rd_id    <= '0;
        end else begin
            r_cnt    <= r_cnt_d;
            ar_ready <= ar_ready_d;
            rd_valid <= rd_valid_d;
            rd_last  <= rd_last_d;
            rd_data  <= rd_data_d;
            rd_resp  <= rd_resp_d;
            if (ar_hs) rd_id <= SLAVE_RD_ADDR_ID;
        end
    end

    assign SLAVE_RD_ADDR_READY = ar_ready;
    assign SLAVE_RD_DATA_VALID = rd_valid;
    assign SLAVE_RD_DATA_LAST  = rd_last;
    assign SLAVE_RD_DATA       = rd_data;
    assign SLAVE_RD_DATA_RESP  = rd_resp;
    assign SLAVE_RD_BACK_ID    = rd_id;
    assign DBG_RD_STATE        = r_state;

    // -----------------------------------------------------------------------
    // Debug: error counters and last offending address
    // -----------------------------------------------------------------------
    axi_slave_decerr_sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
        .clk (clk),
        .clr (rst),
        .inc (wr_inc),
        .cnt (WR_ERR_CNT)
    );

    axi_slave_decerr_sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
        .clk (clk),
        .clr (rst),
        .inc (rd_inc),
        .cnt (RD_ERR_CNT)
    );

    // Write address wins when both address channels accept in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ERR_ADDR <= '0;
        end else if (aw_hs) begin
            ERR_ADDR <= SLAVE_WR_ADDR;
        end else if (ar_hs) begin
            ERR_ADDR <= SLAVE_RD_ADDR;
        end
    end

endmodule

// File: tb/tb_axi_slave_decerr.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_decerr
//   Directed bench for axi_slave_decerr. A second instance with a 2-bit
//   counter width shares all inputs and is used for counter saturation.
// ---------------------------------------------------------------------------
module tb_axi_slave_decerr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared inputs
  logic [3:0]  aw_id, ar_id;
  logic [31:0] aw_addr, ar_addr, w_data;
  logic [7:0]  aw_len, ar_len;
  logic [1:0]  aw_burst, ar_burst;
  logic [3:0]  w_strb;
  logic        aw_valid, w_last, w_valid, b_ready, ar_valid, r_ready;

  // main instance outputs
  logic        s_clk, s_rstn, aw_ready, w_ready, b_valid, ar_ready;
  logic        r_last, r_valid, dbg_r;
  logic [3:0]  b_id, r_id;
  logic [1:0]  b_resp, r_resp, dbg_w;
  logic [31:0] r_data, err_addr;
  logic [15:0] wr_cnt, rd_cnt;

  // narrow-counter instance outputs
  logic        s2_clk, s2_rstn, s2_aw_ready, s2_w_ready, s2_b_valid, s2_ar_ready;
  logic        s2_r_last, s2_r_valid, s2_dbg_r;
  logic [3:0]  s2_b_id, s2_r_id;
  logic [1:0]  s2_b_resp, s2_r_resp, s2_dbg_w;
  logic [31:0] s2_r_data, s2_err_addr;
  logic [1:0]  s2_wr_cnt, s2_rd_cnt;

  int n_cmp = 0;
  int n_err = 0;

  axi_slave_decerr dut (
    .clk(clk), .rst(rst), .SLAVE_CLK(s_clk), .SLAVE_RSTN(s_rstn),
    .SLAVE_WR_ADDR_ID(aw_id), .SLAVE_WR_ADDR(aw_addr), .SLAVE_WR_ADDR_LEN(aw_len),
    .SLAVE_WR_ADDR_BURST(aw_burst), .SLAVE_WR_ADDR_VALID(aw_valid),
    .SLAVE_WR_ADDR_READY(aw_ready),
    .SLAVE_WR_DATA(w_data), .SLAVE_WR_STRB(w_strb), .SLAVE_WR_DATA_LAST(w_last),
    .SLAVE_WR_DATA_VALID(w_valid), .SLAVE_WR_DATA_READY(w_ready),
    .SLAVE_WR_BACK_ID(b_id), .SLAVE_WR_BACK_RESP(b_resp),
    .SLAVE_WR_BACK_VALID(b_valid), .SLAVE_WR_BACK_READY(b_ready),
    .SLAVE_RD_ADDR_ID(ar_id), .SLAVE_RD_ADDR(ar_addr), .SLAVE_RD_ADDR_LEN(ar_len),
    .SLAVE_RD_ADDR_BURST(ar_burst), .SLAVE_RD_ADDR_VALID(ar_valid),
    .SLAVE_RD_ADDR_READY(ar_ready),
    .SLAVE_RD_BACK_ID(r_id), .SLAVE_RD_DATA(r_data), .SLAVE_RD_DATA_RESP(r_resp),
    .SLAVE_RD_DATA_LAST(r_last), .SLAVE_RD_DATA_VALID(r_valid),
    .SLAVE_RD_DATA_READY(r_ready),
    .WR_ERR_CNT(wr_cnt), .RD_ERR_CNT(rd_cnt), .ERR_ADDR(err_addr),
    .DBG_WR_STATE(dbg_w), .DBG_RD_STATE(dbg_r)
  );

  axi_slave_decerr #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .SLAVE_CLK(s2_clk), .SLAVE_RSTN(s2_rstn),
    .SLAVE_WR_ADDR_ID(aw_id), .SLAVE_WR_ADDR(aw_addr), .SLAVE_WR_ADDR_LEN(aw_len),
    .SLAVE_WR_ADDR_BURST(aw_burst), .SLAVE_WR_ADDR_VALID(aw_valid),
    .SLAVE_WR_ADDR_READY(s2_aw_ready),
    .SLAVE_WR_DATA(w_data), .SLAVE_WR_STRB(w_strb), .SLAVE_WR_DATA_LAST(w_last),
    .SLAVE_WR_DATA_VALID(w_valid), .SLAVE_WR_DATA_READY(s2_w_ready),
    .SLAVE_WR_BACK_ID(s2_b_id), .SLAVE_WR_BACK_RESP(s2_b_resp),
    .SLAVE_WR_BACK_VALID(s2_b_valid), .SLAVE_WR_BACK_READY(b_ready),
    .SLAVE_RD_ADDR_ID(ar_id), .SLAVE_RD_ADDR(ar_addr), .SLAVE_RD_ADDR_LEN(ar_len),
    .SLAVE_RD_ADDR_BURST(ar_burst), .SLAVE_RD_ADDR_VALID(ar_valid),
    .SLAVE_RD_ADDR_READY(s2_ar_ready),
    .SLAVE_RD_BACK_ID(s2_r_id), .SLAVE_RD_DATA(s2_r_data), .SLAVE_RD_DATA_RESP(s2_r_resp),
    .SLAVE_RD_DATA_LAST(s2_r_last), .SLAVE_RD_DATA_VALID(s2_r_valid),
    .SLAVE_RD_DATA_READY(r_ready),
    .WR_ERR_CNT(s2_wr_cnt), .RD_ERR_CNT(s2_rd_cnt), .ERR_ADDR(s2_err_addr),
    .DBG_WR_STATE(s2_dbg_w), .DBG_RD_STATE(s2_dbg_r)
  );

  // every registered output of the main instance, for reset checks (114 bits)
  logic [113:0] all_out;
  assign all_out = {aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready, r_id, r_data,
                    r_resp, r_last, r_valid, wr_cnt, rd_cnt, err_addr};

  // ---------------- clock / reset helpers ----------------
  task tick;
    @(posedge clk);
    #1;
  endtask

  task idle_inputs;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = 2'b01; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = 2'b01; ar_valid = 1'b0;
    r_ready = 1'b0;
  endtask

  task do_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- driver: one single-beat write ----------------
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr);
    int k;
    bit timed_out;
    timed_out = 1'b0;
    aw_id = id; aw_addr = addr; aw_valid = 1'b1; b_ready = 1'b1;
    k = 0;
    while (aw_ready !== 1'b1 && k < 20) begin tick(); k++; end
    if (k >= 20) timed_out = 1'b1;
    tick();
    aw_valid = 1'b0;
    w_valid = 1'b1; w_last = 1'b1; w_data = $urandom; w_strb = 4'hF;
    k = 0;
    while (w_ready !== 1'b1 && k < 20) begin tick(); k++; end
    if (k >= 20) timed_out = 1'b1;
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    k = 0;
    while (b_valid !== 1'b1 && k < 20) begin tick(); k++; end
    if (k >= 20) timed_out = 1'b1;
    tick();
    if (timed_out) begin
      n_cmp++; n_err++;
      $display("FAIL write_timeout: handshake not completed within 20 cycles (id=%0d)", id);
    end
  endtask

  // ---------------- tests ----------------
  task test_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    n_cmp++;
    if (s_rstn !== 1'b0) begin
      n_err++; $display("FAIL reset_rstn: got %b expected 0", s_rstn);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({aw_ready, ar_ready, w_ready, b_valid, r_valid, s_rstn} !== 6'b110001) begin
      n_err++;
      $display("FAIL reset_release: aw_rdy/ar_rdy/w_rdy/bv/rv/rstn got %b expected 110001",
               {aw_ready, ar_ready, w_ready, b_valid, r_valid, s_rstn});
    end
  endtask

  task test_single_write;
    do_reset();
    aw_id = 4'd3; aw_addr = 32'h4000_0000; aw_len = 8'd0; aw_valid = 1'b1; b_ready = 1'b1;
    n_cmp++;
    if (aw_ready !== 1'b1) begin
      n_err++; $display("FAIL wr_aw_ready: got %b expected 1", aw_ready);
    end
    tick();  // AW handshake (T)
    aw_valid = 1'b0;
    n_cmp++;
    if ({aw_ready, w_ready, b_valid} !== 3'b010) begin
      n_err++; $display("FAIL wr_after_aw: aw/w/b got %b expected 010", {aw_ready, w_ready, b_valid});
    end
    w_valid = 1'b1; w_last = 1'b1; w_data = 32'h1234_5678; w_strb = 4'hF;
    tick();  // W handshake (T+1)
    w_valid = 1'b0; w_last = 1'b0;
    n_cmp++;
    if ({b_valid, b_id, b_resp, w_ready} !== {1'b1, 4'd3, 2'b11, 1'b0}) begin
      n_err++;
      $display("FAIL wr_bresp: valid/id/resp/wrdy got %b/%0d/%b/%b expected 1/3/11/0",
               b_valid, b_id, b_resp, w_ready);
    end
    tick();  // B handshake (T+2)
    n_cmp++;
    if ({b_valid, aw_ready} !== 2'b01) begin
      n_err++; $display("FAIL wr_aw_again: bvalid/aw_ready got %b expected 01", {b_valid, aw_ready});
    end
    n_cmp++;
    if (wr_cnt !== 16'd1 || rd_cnt !== 16'd0) begin
      n_err++; $display("FAIL wr_counts: wr=%0d rd=%0d expected 1 0", wr_cnt, rd_cnt);
    end
    n_cmp++;
    if (err_addr !== 32'h4000_0000) begin
      n_err++; $display("FAIL wr_err_addr: got %h expected 40000000", err_addr);
    end
  endtask

  task test_read_toggle;
    int beats;
    do_reset();
    ar_id = 4'd5; ar_addr = 32'h6000_0000; ar_len = 8'd3; ar_valid = 1'b1; r_ready = 1'b0;
    tick();  // AR handshake
    ar_valid = 1'b0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      r_ready = (c % 2 == 0);
      n_cmp++;
      if ({r_valid, r_data, r_resp, r_id, r_last} !==
          {1'b1, 32'hDEAD_BEEF, 2'b11, 4'd5, (beats == 3)}) begin
        n_err++;
        $display("FAIL rd_beat%0d: v/data/resp/id/last got %b/%h/%b/%0d/%b expected 1/deadbeef/11/5/%b",
                 beats, r_valid, r_data, r_resp, r_id, r_last, (beats == 3));
      end
      if (r_ready) beats++;
      tick();
    end
    r_ready = 1'b0;
    n_cmp++;
    if (beats !== 4) begin
      n_err++; $display("FAIL rd_beat_count: got %0d expected 4", beats);
    end
    n_cmp++;
    if ({r_valid, ar_ready} !== 2'b01) begin
      n_err++; $display("FAIL rd_ar_again: rvalid/ar_ready got %b expected 01", {r_valid, ar_ready});
    end
    n_cmp++;
    if (rd_cnt !== 16'd1 || err_addr !== 32'h6000_0000) begin
      n_err++; $display("FAIL rd_cnt_addr: cnt=%0d addr=%h expected 1 60000000", rd_cnt, err_addr);
    end
    r_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (r_valid !== 1'b0) begin
      n_err++; $display("FAIL rd_no_extra: rvalid got %b expected 0", r_valid);
    end
  endtask

  task test_concurrent;
    int wb, rb;
    bit bdone;
    do_reset();
    aw_id = 4'd7; aw_addr = 32'h1111_0000; aw_valid = 1'b1;
    ar_id = 4'd2; ar_addr = 32'h2222_0000; ar_len = 8'd0; ar_valid = 1'b1;
    n_cmp++;
    if ({aw_ready, ar_ready} !== 2'b11) begin
      n_err++; $display("FAIL cc_readies: got %b expected 11", {aw_ready, ar_ready});
    end
    tick();  // simultaneous AW + AR handshake
    aw_valid = 1'b0; ar_valid = 1'b0;
    n_cmp++;
    if (err_addr !== 32'h1111_0000) begin
      n_err++; $display("FAIL cc_err_addr: got %h expected 11110000", err_addr);
    end
    wb = 0; rb = 0; bdone = 1'b0;
    r_ready = 1'b1; b_ready = 1'b1;
    for (int c = 0; c < 400 && !(bdone && rb == 1 && wb == 256); c++) begin
      w_valid = (wb < 256); w_last = (wb == 255); w_data = $urandom; w_strb = 4'hF;
      if (r_valid === 1'b1) begin
        n_cmp++;
        if ({r_last, r_id, r_resp, r_data} !== {1'b1, 4'd2, 2'b11, 32'hDEAD_BEEF}) begin
          n_err++;
          $display("FAIL cc_rbeat: last/id/resp/data got %b/%0d/%b/%h expected 1/2/11/deadbeef",
                   r_last, r_id, r_resp, r_data);
        end
        rb++;
      end
      if (b_valid === 1'b1) begin
        n_cmp++;
        if ({b_id, b_resp} !== {4'd7, 2'b11} || wb != 256) begin
          n_err++;
          $display("FAIL cc_bresp: id/resp got %0d/%b after %0d beats expected 7/11 after 256",
                   b_id, b_resp, wb);
        end
        bdone = 1'b1;
      end
      if (w_valid && w_ready === 1'b1) wb++;
      tick();
    end
    w_valid = 1'b0; w_last = 1'b0;
    n_cmp++;
    if (wb !== 256 || rb !== 1 || bdone !== 1'b1) begin
      n_err++; $display("FAIL cc_done: wbeats=%0d rbeats=%0d b=%b expected 256 1 1", wb, rb, bdone);
    end
    n_cmp++;
    if (wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin
      n_err++; $display("FAIL cc_counts: wr=%0d rd=%0d expected 1 1", wr_cnt, rd_cnt);
    end
  endtask

  task test_backpressure;
    do_reset();
    // write data before its address must stall
    w_valid = 1'b1; w_last = 1'b1; w_data = 32'hCAFE_0001; w_strb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({w_ready, b_valid} !== 2'b00) begin
        n_err++; $display("FAIL bp_early_w%0d: wrdy/bvalid got %b expected 00", i, {w_ready, b_valid});
      end
    end
    aw_id = 4'd9; aw_addr = 32'h5000_0010; aw_valid = 1'b1; b_ready = 1'b0;
    tick();  // AW handshake
    aw_valid = 1'b0;
    tick();  // W handshake with the already-waiting beat
    w_valid = 1'b0; w_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({b_valid, b_id, b_resp, aw_ready} !== {1'b1, 4'd9, 2'b11, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold%0d: bv/id/resp/awrdy got %b/%0d/%b/%b expected 1/9/11/0",
                 i, b_valid, b_id, b_resp, aw_ready);
      end
      tick();
    end
    b_ready = 1'b1;
    tick();
    n_cmp++;
    if ({b_valid, aw_ready} !== 2'b01 || wr_cnt !== 16'd1) begin
      n_err++; $display("FAIL bp_release: bv/awrdy got %b cnt=%0d expected 01 cnt=1",
                        {b_valid, aw_ready}, wr_cnt);
    end
  endtask

  task test_reset_mid_read;
    bit seen_valid;
    do_reset();
    ar_id = 4'd4; ar_addr = 32'h3000_0000; ar_len = 8'd7; ar_valid = 1'b1; r_ready = 1'b1;
    tick();  // AR handshake
    ar_valid = 1'b0;
    tick();  // beat 1 handshake
    n_cmp++;
    if ({r_valid, r_last} !== 2'b10) begin
      n_err++; $display("FAIL mr_beat2: valid/last got %b expected 10", {r_valid, r_last});
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL mr_reset_outputs: got %h expected 0", all_out);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (ar_ready !== 1'b1) begin
      n_err++; $display("FAIL mr_ar_ready: got %b expected 1", ar_ready);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (r_valid !== 1'b0) seen_valid = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen_valid !== 1'b0 || rd_cnt !== 16'd0) begin
      n_err++; $display("FAIL mr_residual: beat_seen=%b rd_cnt=%0d expected 0 0", seen_valid, rd_cnt);
    end
    r_ready = 1'b0;
  endtask

  task test_saturation;
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_write(4'(i), 32'h7000_0000 + 32'(i));
      n_cmp++;
      if (s2_wr_cnt !== sat_exp[i] || wr_cnt !== 16'(i + 1)) begin
        n_err++;
        $display("FAIL sat_write%0d: narrow=%0d wide=%0d expected %0d %0d",
                 i, s2_wr_cnt, wr_cnt, sat_exp[i], i + 1);
      end
    end
    n_cmp++;
    if (err_addr !== 32'h7000_0004) begin
      n_err++; $display("FAIL sat_err_addr: got %h expected 70000004", err_addr);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_read_toggle();
    test_concurrent();
    test_backpressure();
    test_reset_mid_read();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_slave_decerr.md
Name: axi_slave_decerr

Overview:
- AXI4 slave that the bus interconnect routes every unmapped or unconnected address to.
- Fully completes every write and read transaction with RESP=2'b11 (address not found), so masters never hang on a missing slave.
- Sits directly downstream of the interconnect slave port and uses the same SLAVE_* channel set as the other slaves.
- Also exports saturating error counters and the last offending address for debug.

Parameters:
- DATA_PATTERN, 32'hDEAD_BEEF, value driven on SLAVE_RD_DATA for every read beat.
- CNT_WIDTH, 16, width of the write and read error counters.

Ports:
- clk  in  1  block clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- SLAVE_CLK  out  1  = clk.
- SLAVE_RSTN  out  1  = ~rst.
- SLAVE_WR_ADDR_ID / _ADDR / _LEN / _BURST / _VALID  in  4/32/8/2/1  write address channel.
- SLAVE_WR_ADDR_READY  out  1  write address ready.
- SLAVE_WR_DATA / _STRB / _LAST / _VALID  in  32/4/1/1  write data channel.
- SLAVE_WR_DATA_READY  out  1  write data ready.
- SLAVE_WR_BACK_ID / _RESP / _VALID  out  4/2/1  write response channel.
- SLAVE_WR_BACK_READY  in  1  write response ready.
- SLAVE_RD_ADDR_ID / _ADDR / _LEN / _BURST / _VALID  in  4/32/8/2/1  read address channel.
- SLAVE_RD_ADDR_READY  out  1  read address ready.
- SLAVE_RD_BACK_ID / _DATA / _DATA_RESP / _DATA_LAST / _DATA_VALID  out  4/32/2/1/1  read data channel.
- SLAVE_RD_DATA_READY  in  1  read data ready.
- WR_ERR_CNT  out  CNT_WIDTH  count of completed write responses.
- RD_ERR_CNT  out  CNT_WIDTH  count of completed read bursts.
- ERR_ADDR  out  32  address of the most recently accepted offending transaction.

Behaviour:
- Reset: synchronous, active-high, applied on the rising clk edge while rst=1.
  - All outputs registered and reset to 0 (READYs, VALIDs, IDs, RESPs, LAST, RD_DATA, counters, ERR_ADDR).
  - Both FSMs go to IDLE; READYs rise on the first cycle after rst deasserts.
  - rst mid-burst aborts the burst immediately; no pending response is emitted afterwards.
- The write FSM and read FSM are independent; concurrent write and read traffic is legal.
- Write FSM:
  - W_IDLE (AW_READY=1): on AW handshake latch ID and ADDR, set ERR_ADDR, go to W_DATA with AW_READY=0 and WR_DATA_READY=1 the next cycle.
  - W_DATA: accept and discard every beat (DATA and STRB ignored). On a handshake with LAST=1 go to W_RESP; BACK_VALID=1, BACK_ID=latched ID, BACK_RESP=2'b11 the next cycle.
  - W_RESP: hold BVALID/ID/RESP stable until BACK_READY=1. On handshake increment WR_ERR_CNT, go to W_IDLE; AW_READY=1 the next cycle.
- Write boundary rules:
  - WR_DATA_READY=0 outside W_DATA, so write data arriving before its address stalls.
  - Write burst length is taken from LAST only; LEN and BURST are ignored.
- Read FSM:
  - R_IDLE (RD_ADDR_READY=1): on AR handshake latch ID, load beat counter = LEN, set ERR_ADDR, go to R_DATA. The first beat is valid the next cycle.
  - R_DATA: RD_DATA_VALID=1, DATA=DATA_PATTERN, RESP=2'b11, ID=latched ID, LAST=(counter==0). Outputs hold while RD_DATA_READY=0.
    - On a handshake with counter!=0: decrement the counter.
    - On a handshake with counter==0: increment RD_ERR_CNT, go to R_IDLE.
  - Back-to-back beats at one per cycle while RD_DATA_READY=1.
- Read boundary rules:
  - LEN=0 gives a single beat with LAST=1.
  - LEN=255 gives 256 beats; the 8-bit counter never wraps below 0.
- Latency:
  - Minimum write: AW at T, W at T+1, B at T+2, AW_READY again at T+3.
  - Minimum read: AR at T, first R beat at T+1, ARREADY again one cycle after the RLAST handshake.
- Counters saturate at all-ones and never wrap.
- ERR_ADDR priority: if AW and AR handshake in the same cycle, ERR_ADDR takes the write address.

Decomposition:
- Shared axi package holds:
  - RESP encodings: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - ID/ADDR/DATA/LEN width constants.
  - FSM state enums for the write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs.
- One sub-module is natural: sat_counter (parameterised width, inc, synchronous clear), instantiated twice.

Test Plan:
- Single write: AW ID=3 ADDR=0x4000_0000, one W beat with LAST, BREADY=1 -> B at T+2 with ID=3, RESP=11; WR_ERR_CNT=1; ERR_ADDR=0x4000_0000.
- Read: LEN=3 ID=5, RREADY toggling 1/0 -> exactly 4 beats, each DATA=0xDEAD_BEEF and RESP=11; LAST only on beat 4; outputs stable while stalled; RD_ERR_CNT=1.
- Concurrency and edge lengths:
  - Write of 256 beats concurrent with a read of LEN=0 -> both complete independently.
  - Same-cycle AW/AR handshakes -> ERR_ADDR equals the write address.
- Backpressure: BREADY held 0 for 10 cycles -> BVALID/ID/RESP stable for all 10 cycles; AW_READY stays 0 until the B handshake.
- Reset mid-read: rst asserted on beat 2 of a LEN=7 burst -> next cycle all outputs 0; after release ARREADY=1 with no residual beats.
- Saturation: CNT_WIDTH=2, 5 writes -> WR_ERR_CNT sequence 1,2,3,3,3.
